// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add over a 2*bw accumulator, divide is restoring division,
// one iteration per cycle, so the latency is bw+1 edges (1 for divide by zero).
// Build option MULDIV_SIGNED_EN: when defined, sgn=1 selects two's-complement
// operation. Operands are reduced to magnitudes at the start edge and the
// result signs are fixed up in FIN. When it is undefined, sgn is ignored.
module muldiv #(
   parameter int bw = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [bw-1:0] a,
   input  logic [bw-1:0] b,
   input  logic          start,
   input  logic          op,
   input  logic          sgn,
   output logic          busy,
   output logic          done,
   output logic          dbz,
   output logic [bw-1:0] hi,
   output logic [bw-1:0] lo
);

   localparam int CW = $clog2(bw + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*bw-1:0]   acc_q, acc_d;
   logic [bw-1:0]     rem_q, rem_d;
   logic [bw-1:0]     opb_q, opb_d;
   logic              op_q, op_d;
   logic [bw-1:0]     hi_q, hi_d;
   logic [bw-1:0]     lo_q, lo_d;
   logic              done_q, done_d;
   logic              dbz_q, dbz_d;

   logic [bw-1:0]     a_mag;
   logic [bw-1:0]     b_mag;
   logic [bw:0]       mul_sum;
   logic [2*bw-1:0]   mul_next;
   logic [bw:0]       div_shift;
   logic [bw:0]       div_trial;
   logic [2*bw-1:0]   prod_fix;
   logic [bw-1:0]     quo_fix;
   logic [bw-1:0]     rem_fix;

`ifdef MULDIV_SIGNED_EN
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;

   // Reduce signed operands to magnitudes so the unsigned core can be reused.
   always_comb begin
      a_mag = a;
      b_mag = b;
      if (sgn && a[bw-1]) begin
         a_mag = ~a + 1'b1;
      end
      if (sgn && b[bw-1]) begin
         b_mag = ~b + 1'b1;
      end
   end

   // Remember at the start edge which result parts need negating in FIN.
   always_comb begin
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      if (state_q == IDLE && start) begin
         if (op && b == '0) begin
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
         end else begin
            neg_res_d = sgn & (a[bw-1] ^ b[bw-1]);
            neg_rem_d = sgn & a[bw-1];
         end
      end
   end

   // Sign flags register; cleared by reset so an aborted op leaves no trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   // Apply the sign fixup to the unsigned core result.
   always_comb begin
      prod_fix = acc_q;
      quo_fix  = acc_q[bw-1:0];
      rem_fix  = rem_q;
      if (neg_res_q) begin
         prod_fix = ~acc_q + 1'b1;
         quo_fix  = ~acc_q[bw-1:0] + 1'b1;
      end
      if (neg_rem_q) begin
         rem_fix = ~rem_q + 1'b1;
      end
   end
`else
   logic              unused_sgn;

   assign unused_sgn = sgn;
   assign a_mag      = a;
   assign b_mag      = b;
   assign prod_fix   = acc_q;
   assign quo_fix    = acc_q[bw-1:0];
   assign rem_fix    = rem_q;
`endif

   // One iteration of each algorithm, computed from the current working state.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*bw-1:bw]} + {1'b0, (acc_q[0] ? opb_q : {bw{1'b0}})};
      mul_next  = {mul_sum, acc_q[bw-1:1]};
      div_shift = {rem_q, acc_q[bw-1]};
      div_trial = div_shift - {1'b0, opb_q};
   end

   // Next-state and datapath control; everything holds unless a state acts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      opb_d   = opb_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d  = op;
               opb_d = b_mag;
               dbz_d = 1'b0;
               if (op && b == '0) begin
                  // Divide by zero: preload the final HI/LO pattern and finish.
                  state_d = FIN;
                  dbz_d   = 1'b1;
                  acc_d   = {{bw{1'b0}}, {bw{1'b1}}};
                  rem_d   = a;
                  cnt_d   = '0;
               end else begin
                  state_d = RUN;
                  cnt_d   = CW'(bw);
                  acc_d   = {{bw{1'b0}}, a_mag};
                  rem_d   = '0;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (op_q) begin
               if (!div_trial[bw]) begin
                  rem_d = div_trial[bw-1:0];
                  acc_d = {acc_q[2*bw-1:bw], acc_q[bw-2:0], 1'b1};
               end else begin
                  rem_d = div_shift[bw-1:0];
                  acc_d = {acc_q[2*bw-1:bw], acc_q[bw-2:0], 1'b0};
               end
            end else begin
               acc_d = mul_next;
            end
            if (cnt_q == CW'(1)) begin
               state_d = FIN;
            end
         end
         FIN: begin
            if (op_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*bw-1:bw];
               lo_d = prod_fix[bw-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         opb_q   <= '0;
         op_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign dbz  = dbz_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized scoreboard bench for muldiv. The driver pushes the
// expected HI/LO/dbz and latency for each accepted start; a monitor pops and
// compares on every done pulse and checks HI/LO hold steady otherwise.
module tb_muldiv;

   localparam int BW = 8;
`ifdef MULDIV_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   typedef struct {
      logic [BW-1:0] hi;
      logic [BW-1:0] lo;
      logic          dbz;
      int            accept;
      int            lat;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [BW-1:0] a;
   logic [BW-1:0] b;
   logic          start;
   logic          op;
   logic          sgn;
   logic          busy;
   logic          done;
   logic          dbz;
   logic [BW-1:0] hi;
   logic [BW-1:0] lo;

   int            cycle = 0;
   int            nChecks = 0;
   int            nFails = 0;
   exp_t          sb[$];
   logic [BW-1:0] lastHi = '0;
   logic [BW-1:0] lastLo = '0;

   muldiv #(.bw(BW)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .start (start),
      .op    (op),
      .sgn   (sgn),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure latency from the accepting edge.
   always @(posedge clk) begin
      cycle++;
   end

   // Reference model: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [BW-1:0] av, input logic [BW-1:0] bv,
                                  input logic opv, input logic sgv);
      exp_t e;
      int   sa;
      int   sbv;
      int   p;
      int   q;
      int   r;
      bit   useS;
      useS  = SIGNED_EN && sgv;
      sa    = useS ? int'($signed(av)) : int'(av);
      sbv   = useS ? int'($signed(bv)) : int'(bv);
      e.dbz = 1'b0;
      e.lat = BW + 1;
      e.accept = 0;
      if (!opv) begin
         p    = sa * sbv;
         e.hi = p[15:8];
         e.lo = p[7:0];
      end else if (bv == '0) begin
         e.hi  = av;
         e.lo  = '1;
         e.dbz = 1'b1;
         e.lat = 1;
      end else begin
         q    = sa / sbv;
         r    = sa % sbv;
         e.lo = q[7:0];
         e.hi = r[7:0];
      end
      return e;
   endfunction

   // Single comparison point: counts every check and reports failures.
   task automatic checkOutput(input string name, input int act, input int expv);
      nChecks++;
      if (act !== expv) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cycle);
      end
   endtask

   // Issue one operation; must be called right after a negedge. Waits for
   // busy to drop, so consecutive calls exercise back-to-back starts.
   task automatic applyStimulus(input logic [BW-1:0] av, input logic [BW-1:0] bv,
                                input logic opv, input logic sgv);
      int   guard;
      exp_t e;
      guard = 0;
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (busy) begin
         checkOutput("busy_timeout", int'(busy), 0);
         return;
      end
      a     = av;
      b     = bv;
      op    = opv;
      sgn   = sgv;
      start = 1'b1;
      @(posedge clk);
      #1;
      e        = model(av, bv, opv, sgv);
      e.accept = cycle;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a     = BW'($urandom);
      b     = BW'($urandom);
      op    = 1'($urandom);
      sgn   = 1'($urandom);
   endtask

   // Monitor: compare on done, otherwise require HI/LO to hold.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", int'(done), 0);
            end else begin
               e = sb.pop_front();
               checkOutput("hi", int'(hi), int'(e.hi));
               checkOutput("lo", int'(lo), int'(e.lo));
               checkOutput("dbz", int'(dbz), int'(e.dbz));
               checkOutput("busy_at_done", int'(busy), 0);
               checkOutput("latency", cycle - e.accept, e.lat);
               lastHi = e.hi;
               lastLo = e.lo;
            end
         end else begin
            checkOutput("hold_hi", int'(hi), int'(lastHi));
            checkOutput("hold_lo", int'(lo), int'(lastLo));
         end
      end
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed vectors, random ops, reset abort, drain.
   initial begin
      int   guard;
      logic [BW-1:0] ra;
      logic [BW-1:0] rb;
      logic          rop;
      rst   = 1'b1;
      a     = '0;
      b     = '0;
      start = 1'b0;
      op    = 1'b0;
      sgn   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_dbz", int'(dbz), 0);
      checkOutput("reset_hi", int'(hi), 0);
      checkOutput("reset_lo", int'(lo), 0);
      #2 rst = 1'b0;
      @(negedge clk);

      applyStimulus(8'd200, 8'd3, 1'b0, 1'b0);
      applyStimulus(8'd100, 8'd7, 1'b1, 1'b0);
      applyStimulus(8'h37, 8'h00, 1'b1, 1'b0);
      applyStimulus(8'd9, 8'd4, 1'b0, 1'b0);

      // Start while busy must be ignored.
      applyStimulus(8'd200, 8'd3, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("busy_mid_op", int'(busy), 1);
      a     = 8'd1;
      b     = 8'd1;
      op    = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      applyStimulus(8'hFA, 8'd5, 1'b0, 1'b1);
      applyStimulus(8'hF9, 8'd2, 1'b1, 1'b1);
      applyStimulus(8'hFA, 8'd5, 1'b0, 1'b0);
      applyStimulus(8'hF9, 8'd2, 1'b1, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
      applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      applyStimulus(8'd5, 8'd9, 1'b1, 1'b0);
      applyStimulus(8'h80, 8'hFF, 1'b1, 1'b1);
      applyStimulus(8'h80, 8'h00, 1'b1, 1'b1);

      for (int i = 0; i < 40; i++) begin
         ra  = BW'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom);
         rop = 1'($urandom);
         applyStimulus(ra, rb, rop, 1'($urandom));
      end

      // Asynchronous reset part-way through a divide aborts it.
      applyStimulus(8'd100, 8'd7, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_hi", int'(hi), 0);
      checkOutput("abort_lo", int'(lo), 0);
      checkOutput("abort_done", int'(done), 0);
      sb.delete();
      lastHi = '0;
      lastLo = '0;
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (15) @(negedge clk);

      applyStimulus(8'd13, 8'd11, 1'b0, 1'b0);
      applyStimulus(8'd250, 8'd16, 1'b1, 1'b0);

      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("scoreboard_drained", sb.size(), 0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
